// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Purpose  : Memory-access pipeline stage. Non-memory instructions pass the
//            ALU result straight to write-back. Loads and stores
//            (B/H/W, signed and unsigned) are serialised one byte per cycle
//            onto a byte-wide synchronous RAM port. The upstream pipeline is
//            stalled until the access finishes.
// Ports    : clk, rst (async, active-low)
//            ex_*   : EX/MEM register contents (wd, wreg, wdata, memop,
//                     funct3, mem_addr, store_data)
//            ram_*  : byte RAM port (addr, we, wdata out; rdata in, one-cycle
//                     read latency)
//            stall_req    : hold EX/MEM and all earlier stages
//            mem_*        : write-back inputs of the MEM/WB register
//            mem_misalign : one-cycle misaligned-access pulse
// Options  : MEM_MISALIGN_CHK_EN - misaligned H/HU/W accesses are rejected
//            without touching the RAM, and mem_misalign pulses. Without it,
//            misaligned accesses are performed byte by byte like aligned ones.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access #(
    parameter int RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ex_wd,
    input  logic              ex_wreg,
    input  logic [31:0]       ex_wdata,
    input  logic [1:0]        ex_memop,
    input  logic [2:0]        ex_funct3,
    input  logic [31:0]       ex_mem_addr,
    input  logic [31:0]       ex_store_data,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              stall_req,
    output logic [4:0]        mem_wd,
    output logic              mem_wreg,
    output logic [31:0]       mem_wdata,
    output logic              mem_misalign
);

    localparam logic [1:0] C_OP_LOAD  = 2'b01;
    localparam logic [1:0] C_OP_STORE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_cnt;
    logic [1:0]        w_cnt_nxt;
    logic [31:0]       r_acc;
    logic [RAM_AW-1:0] r_base;
    logic [2:0]        r_funct3;
    logic              r_is_load;
    logic [RAM_AW-1:0] r_addr_hold;
    logic [7:0]        r_wdata_hold;
    logic              r_mis;

    logic              w_is_load;
    logic              w_is_store;
    logic              w_is_mem;
    logic              w_misalign;
    logic [1:0]        w_last_ex;
    logic [1:0]        w_last_r;
    logic              w_sample;
    logic              w_capture;
    logic              w_present;
    logic              w_we;
    logic [RAM_AW-1:0] w_present_addr;
    logic [RAM_AW-1:0] w_addr_off;
    logic [7:0]        w_wbyte;
    logic [31:0]       w_load_data;
    logic [1:0]        w_cap_idx;
    logic              w_unused;

    // Access size modulo 4: 1, 2, or 0 standing for 4. A 2-bit byte counter
    // then reaches this value exactly when the last byte has been handled.
    function automatic logic [1:0] size_mod4(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_mod4 = 2'd1;
            2'b01:   size_mod4 = 2'd2;
            default: size_mod4 = 2'd0;
        endcase
    endfunction

    assign w_is_load  = (ex_memop == C_OP_LOAD);
    assign w_is_store = (ex_memop == C_OP_STORE);
    assign w_is_mem   = w_is_load | w_is_store;
    assign w_last_ex  = size_mod4(ex_funct3);
    assign w_last_r   = size_mod4(r_funct3);
    assign w_addr_off = r_base + {{(RAM_AW-2){1'b0}}, r_cnt};
    // Byte arriving in RD belongs to the address presented one cycle earlier.
    assign w_cap_idx  = r_cnt - 2'd1;
    // Address bits above the RAM width are intentionally dropped.
    assign w_unused   = ^ex_mem_addr;

`ifdef MEM_MISALIGN_CHK_EN
    assign w_misalign = ((ex_funct3[1:0] == 2'b01) && ex_mem_addr[0]) ||
                        ((ex_funct3 == 3'b010) && (ex_mem_addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mis <= 1'b0;
        end else begin
            r_mis <= (r_state == S_IDLE) && w_is_mem && w_misalign;
        end
    end

    assign mem_misalign = r_mis;
`else
    assign w_misalign   = 1'b0;
    assign r_mis        = 1'b0;
    assign mem_misalign = 1'b0;
`endif

    always_comb begin
        case (r_funct3)
            3'b000:  w_load_data = {{24{r_acc[7]}}, r_acc[7:0]};
            3'b001:  w_load_data = {{16{r_acc[15]}}, r_acc[15:0]};
            3'b100:  w_load_data = {24'd0, r_acc[7:0]};
            3'b101:  w_load_data = {16'd0, r_acc[15:0]};
            default: w_load_data = r_acc;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_sample       = 1'b0;
        w_capture      = 1'b0;
        w_present      = 1'b0;
        w_present_addr = '0;
        w_we           = 1'b0;
        w_wbyte        = 8'd0;
        stall_req      = 1'b0;
        mem_wd         = 5'd0;
        mem_wreg       = 1'b0;
        mem_wdata      = 32'd0;

        case (r_state)
            S_IDLE: begin
                if (!w_is_mem) begin
                    mem_wd    = ex_wd;
                    mem_wreg  = ex_wreg;
                    mem_wdata = ex_wdata;
                end else if (w_misalign) begin
                    // Rejected access: straight to DONE, no stall, no RAM cycle.
                    w_sample    = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    stall_req      = 1'b1;
                    w_sample       = 1'b1;
                    w_present      = 1'b1;
                    w_present_addr = ex_mem_addr[RAM_AW-1:0];
                    if (w_is_load) begin
                        w_state_nxt = S_RD;
                        w_cnt_nxt   = 2'd1;
                    end else begin
                        w_we    = 1'b1;
                        w_wbyte = ex_store_data[7:0];
                        if (w_last_ex == 2'd1) begin
                            w_state_nxt = S_DONE;
                            w_cnt_nxt   = 2'd0;
                        end else begin
                            w_state_nxt = S_WR;
                            w_cnt_nxt   = 2'd1;
                        end
                    end
                end
            end

            S_RD: begin
                stall_req = 1'b1;
                w_capture = 1'b1;
                if (r_cnt == w_last_r) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = 2'd0;
                end else begin
                    w_present      = 1'b1;
                    w_present_addr = w_addr_off;
                    w_cnt_nxt      = r_cnt + 2'd1;
                end
            end

            S_WR: begin
                stall_req      = 1'b1;
                w_present      = 1'b1;
                w_present_addr = w_addr_off;
                w_we           = 1'b1;
                w_wbyte        = ex_store_data[{r_cnt, 3'b000} +: 8];
                if (r_cnt == (w_last_r - 2'd1)) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = 2'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 2'd1;
                end
            end

            default: begin // S_DONE
                mem_wd      = ex_wd;
                mem_wreg    = ex_wreg & r_is_load & ~r_mis;
                mem_wdata   = r_is_load ? w_load_data : 32'd0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // The IDLE-cycle RAM drive is combinational, so it is masked while reset
    // is asserted; otherwise a store waiting upstream would still write.
    assign ram_we    = w_we & rst;
    assign ram_addr  = (w_present & rst) ? w_present_addr : r_addr_hold;
    assign ram_wdata = (w_we & rst) ? w_wbyte : r_wdata_hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 2'd0;
            r_acc        <= 32'd0;
            r_base       <= '0;
            r_funct3     <= 3'd0;
            r_is_load    <= 1'b0;
            r_addr_hold  <= '0;
            r_wdata_hold <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_sample) begin
                r_base    <= ex_mem_addr[RAM_AW-1:0];
                r_funct3  <= ex_funct3;
                r_is_load <= w_is_load;
            end
            if (w_capture) begin
                r_acc[{w_cap_idx, 3'b000} +: 8] <= ram_rdata;
            end
            if (w_present) begin
                r_addr_hold <= w_present_addr;
            end
            if (w_we) begin
                r_wdata_hold <= w_wbyte;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access
// Purpose  : Self-checking bench for mem_access. Drives directed
//            instructions, models a byte RAM, and compares write-back results
//            and RAM write traffic against scoreboard queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    localparam int RAM_AW = 17;

    logic              clk = 1'b0;
    logic              rst;
    logic [4:0]        ex_wd;
    logic              ex_wreg;
    logic [31:0]       ex_wdata;
    logic [1:0]        ex_memop;
    logic [2:0]        ex_funct3;
    logic [31:0]       ex_mem_addr;
    logic [31:0]       ex_store_data;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;
    logic              stall_req;
    logic [4:0]        mem_wd;
    logic              mem_wreg;
    logic [31:0]       mem_wdata;
    logic              mem_misalign;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        mis;
    } wb_t;

    typedef struct {
        logic [RAM_AW-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    wb_t sb_q[$];
    wr_t wr_q[$];
    int  checks = 0;
    int  errors = 0;

    logic [7:0] ram [0:(1<<RAM_AW)-1];

    mem_access #(.RAM_AW(RAM_AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_wd         (ex_wd),
        .ex_wreg       (ex_wreg),
        .ex_wdata      (ex_wdata),
        .ex_memop      (ex_memop),
        .ex_funct3     (ex_funct3),
        .ex_mem_addr   (ex_mem_addr),
        .ex_store_data (ex_store_data),
        .ram_addr      (ram_addr),
        .ram_we        (ram_we),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .stall_req     (stall_req),
        .mem_wd        (mem_wd),
        .mem_wreg      (mem_wreg),
        .mem_wdata     (mem_wdata),
        .mem_misalign  (mem_misalign)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM: write on the edge, read data one cycle later.
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic watch_ram();
        wr_t w;
        if (ram_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                chk("unexpected ram write", 64'(ram_we), 64'd0);
            end else begin
                w = wr_q.pop_front();
                chk("ram_addr", 64'(ram_addr), 64'(w.addr));
                chk("ram_wdata", 64'(ram_wdata), 64'(w.data));
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] wd, input logic wreg,
                          input logic [31:0] alu, input logic [31:0] load_val);
        int  n;
        int  stall_n;
        int  done_c;
        bit  is_ld;
        bit  is_st;
        bit  mis;
        wb_t e;
        wr_t w;
        n     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        is_ld = (op == 2'b01);
        is_st = (op == 2'b10);
        mis   = 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
        if ((is_ld || is_st) &&
            (((f3[1:0] == 2'b01) && addr[0]) || ((f3 == 3'b010) && (addr[1:0] != 2'b00))))
            mis = 1'b1;
`endif
        if (mis) begin
            stall_n = 0; done_c = 1;
        end else if (is_ld) begin
            stall_n = n + 1; done_c = n + 1;
        end else if (is_st) begin
            stall_n = n; done_c = n;
        end else begin
            stall_n = 0; done_c = 0;
        end
        e.wd    = wd;
        e.wreg  = (is_ld && !mis) ? wreg : ((is_ld || is_st) ? 1'b0 : wreg);
        e.wdata = is_ld ? load_val : alu;
        e.mis   = mis;
        sb_q.push_back(e);
        if (is_st && !mis) begin
            for (int k = 0; k < n; k++) begin
                w.addr = addr[RAM_AW-1:0] + RAM_AW'(k);
                w.data = sdata[8*k +: 8];
                wr_q.push_back(w);
            end
        end

        ex_memop = op; ex_funct3 = f3; ex_mem_addr = addr; ex_store_data = sdata;
        ex_wd = wd; ex_wreg = wreg; ex_wdata = alu;

        for (int c = 0; c <= done_c; c++) begin
            @(negedge clk);
            watch_ram();
            chk($sformatf("%s stall_req c%0d", tag, c), 64'(stall_req), 64'(c < stall_n));
            if (c == done_c) begin
                e = sb_q.pop_front();
                chk($sformatf("%s mem_wd", tag), 64'(mem_wd), 64'(e.wd));
                chk($sformatf("%s mem_wreg", tag), 64'(mem_wreg), 64'(e.wreg));
                if (e.wreg) chk($sformatf("%s mem_wdata", tag), 64'(mem_wdata), 64'(e.wdata));
                chk($sformatf("%s mem_misalign", tag), 64'(mem_misalign), 64'(e.mis));
            end else begin
                chk($sformatf("%s bubble c%0d", tag, c), 64'({mem_wd, mem_wreg, mem_wdata}), 64'd0);
                chk($sformatf("%s misalign low c%0d", tag, c), 64'(mem_misalign), 64'd0);
            end
            @(posedge clk);
            #1;
        end
        chk($sformatf("%s pending writes", tag), 64'(wr_q.size()), 64'd0);
    endtask

    initial begin
        wr_t w;
        rst = 1'b0;
        ex_wd = 5'd0; ex_wreg = 1'b0; ex_wdata = 32'd0; ex_memop = 2'b00;
        ex_funct3 = 3'd0; ex_mem_addr = 32'd0; ex_store_data = 32'd0;

        #12;
        chk("reset ram_we", 64'(ram_we), 64'd0);
        chk("reset ram_addr", 64'(ram_addr), 64'd0);
        chk("reset ram_wdata", 64'(ram_wdata), 64'd0);
        chk("reset mem_misalign", 64'(mem_misalign), 64'd0);
        chk("reset stall_req", 64'(stall_req), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        //      tag       op     f3      addr          sdata         wd  wreg alu           load
        run_op("ADD",     2'b00, 3'b000, 32'h0,        32'h0,        5,  1, 32'h0000_1234, 32'h0);
        run_op("RSVDOP",  2'b11, 3'b010, 32'h40,       32'h0,        9,  1, 32'hCAFE_F00D, 32'h0);
        run_op("SW",      2'b10, 3'b010, 32'h100,      32'hDEAD_BEEF, 0, 1, 32'h0,        32'h0);
        run_op("LW",      2'b01, 3'b010, 32'h100,      32'h0,        7,  1, 32'h0,         32'hDEAD_BEEF);
        run_op("LB",      2'b01, 3'b000, 32'h103,      32'h0,        8,  1, 32'h0,         32'hFFFF_FFDE);
        run_op("LBU",     2'b01, 3'b100, 32'h103,      32'h0,        9,  1, 32'h0,         32'h0000_00DE);
        run_op("LH",      2'b01, 3'b001, 32'h100,      32'h0,        10, 1, 32'h0,         32'hFFFF_BEEF);
        run_op("LHU",     2'b01, 3'b101, 32'h102,      32'h0,        11, 1, 32'h0,         32'h0000_DEAD);
        run_op("SB_HI",   2'b10, 3'b000, 32'h0002_0104, 32'hAABB_CC80, 0, 0, 32'h0,        32'h0);
        run_op("LB_104",  2'b01, 3'b000, 32'h104,      32'h0,        12, 1, 32'h0,         32'hFFFF_FF80);
        run_op("SH_WRAP", 2'b10, 3'b001, 32'h0001_FFFF, 32'h0000_A55A, 0, 0, 32'h0,        32'h0);
        run_op("LHU_WRAP",2'b01, 3'b101, 32'h0001_FFFF, 32'h0,       13, 1, 32'h0,         32'h0000_A55A);
        run_op("LH_MIS",  2'b01, 3'b001, 32'h101,      32'h0,        14, 1, 32'h0,         32'hFFFF_ADBE);

        // Store aborted by reset while its third byte is on the port.
        ex_memop = 2'b10; ex_funct3 = 3'b010; ex_mem_addr = 32'h100;
        ex_store_data = 32'h1122_3344; ex_wd = 5'd0; ex_wreg = 1'b0; ex_wdata = 32'd0;
        w.addr = 17'h100; w.data = 8'h44; wr_q.push_back(w);
        w.addr = 17'h101; w.data = 8'h33; wr_q.push_back(w);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            watch_ram();
            @(posedge clk);
            #1;
        end
        chk("abort third byte we", 64'(ram_we), 64'd1);
        chk("abort third byte addr", 64'(ram_addr), 64'h102);
        chk("abort third byte data", 64'(ram_wdata), 64'h22);
        #2 rst = 1'b0;
        #1;
        chk("abort ram_we", 64'(ram_we), 64'd0);
        chk("abort ram_addr", 64'(ram_addr), 64'd0);
        chk("abort mem_wreg", 64'(mem_wreg), 64'd0);
        ex_memop = 2'b00; ex_funct3 = 3'd0; ex_mem_addr = 32'd0; ex_store_data = 32'd0;
        @(negedge clk);
        watch_ram();
        chk("abort stall_req", 64'(stall_req), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("abort pending writes", 64'(wr_q.size()), 64'd0);
        run_op("LW_ABORT", 2'b01, 3'b010, 32'h100, 32'h0, 7, 1, 32'h0, 32'hDEAD_3344);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
